// File: rtl/imm_gen_pipe_pkg.sv
// Shared opcode and format-tag constants for the pipelined immediate generator.
// Extends the original opcodes.v constant set with the 3-bit format tags.
package imm_gen_pipe_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  localparam logic [2:0] F3_SLLI = 3'b001;
  localparam logic [2:0] F3_SRXI = 3'b101;

endpackage

// File: rtl/imm_gen_pipe_stage.sv
// imm_pipe_stage: one elastic register slice holding a payload word and its valid bit.
// Flush clears the valid bit only; reset also zeroes the payload.
import imm_gen_pipe_pkg::*;

module imm_pipe_stage #(
  parameter int W = 36
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;
  logic         advance;

  always_comb begin
    advance = !valid_q || out_ready;
    valid_d = valid_q;
    data_d  = data_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (advance) begin
      valid_d = in_valid;
      if (in_valid) begin
        data_d = in_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign in_ready  = advance;
  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: RV32I/RV64I immediate decoder feeding a DEPTH-stage elastic pipeline.
// Define IMM_GEN_SHAMT_EN to decode shift-immediate shamt fields instead of plain I-format.
import imm_gen_pipe_pkg::*;

module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     inst,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] imm_out,
  output logic [2:0]      fmt,
  output logic            illegal
);

  localparam int PW = XLEN + 4;

  logic [6:0]      opcode;
  logic [31:0]     dec_imm32;
  logic [XLEN-1:0] dec_imm;
  logic [2:0]      dec_fmt;
  logic            dec_illegal;

  assign opcode = inst[6:0];

  // Every format fits in 32 bits already sign-extended; widening to XLEN happens once below.
  always_comb begin
    dec_imm32   = 32'd0;
    dec_fmt     = FMT_R;
    dec_illegal = 1'b0;
    case (opcode)
      OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: begin
        dec_fmt   = FMT_I;
        dec_imm32 = {{20{inst[31]}}, inst[31:20]};
      end
      OP_STORE: begin
        dec_fmt   = FMT_S;
        dec_imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      end
      OP_BRANCH: begin
        dec_fmt   = FMT_B;
        dec_imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin
        dec_fmt   = FMT_U;
        dec_imm32 = {inst[31:12], 12'd0};
      end
      OP_JAL: begin
        dec_fmt   = FMT_J;
        dec_imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      end
      OP_OP: begin
        dec_fmt = FMT_R;
      end
      default: begin
        dec_illegal = 1'b1;
      end
    endcase
`ifdef IMM_GEN_SHAMT_EN
    if (opcode == OP_IMM && (inst[14:12] == F3_SLLI || inst[14:12] == F3_SRXI)) begin
      dec_imm32   = {26'd0, (XLEN == 64) ? inst[25] : 1'b0, inst[24:20]};
      dec_illegal = (XLEN == 32) && inst[25];
    end
`endif
  end

  assign dec_imm = XLEN'($signed(dec_imm32));

  logic          valid_c [DEPTH+1];
  logic          ready_c [DEPTH+1];
  logic [PW-1:0] data_c  [DEPTH+1];

  assign valid_c[0]     = in_valid;
  assign data_c[0]      = {dec_illegal, dec_fmt, dec_imm};
  assign ready_c[DEPTH] = out_ready;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    imm_pipe_stage #(.W(PW)) u_stage (
      .clk      (clk),
      .reset    (reset),
      .flush    (flush),
      .in_valid (valid_c[k]),
      .in_ready (ready_c[k]),
      .in_data  (data_c[k]),
      .out_valid(valid_c[k+1]),
      .out_ready(ready_c[k+1]),
      .out_data (data_c[k+1])
    );
  end

  assign in_ready                 = ready_c[0];
  assign out_valid                = valid_c[DEPTH];
  assign {illegal, fmt, imm_out}  = data_c[DEPTH];

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: four instances cover decode (XLEN 32/64), backpressure,
// flush and mid-stream reset. Shift expectations follow IMM_GEN_SHAMT_EN when it is defined.
module tb_imm_gen_pipe;

  logic clk;
  int   tests_run;
  int   tests_failed;

  logic rst1, flush1, in_valid1, in_ready1, out_valid1, out_ready1, illegal1;
  logic [31:0] inst1, imm1;
  logic [2:0]  fmt1;

  logic rst2, flush2, in_valid2, in_ready2, out_valid2, out_ready2, illegal2;
  logic [31:0] inst2, imm2;
  logic [2:0]  fmt2;

  logic rst3, flush3, in_valid3, in_ready3, out_valid3, out_ready3, illegal3;
  logic [31:0] inst3, imm3;
  logic [2:0]  fmt3;

  logic rst64, flush64, in_valid64, in_ready64, out_valid64, out_ready64, illegal64;
  logic [31:0] inst64;
  logic [63:0] imm64;
  logic [2:0]  fmt64;

  imm_gen_pipe #(.XLEN(32), .DEPTH(1)) u_d1 (
    .clk(clk), .reset(rst1), .flush(flush1), .in_valid(in_valid1), .in_ready(in_ready1),
    .inst(inst1), .out_valid(out_valid1), .out_ready(out_ready1), .imm_out(imm1),
    .fmt(fmt1), .illegal(illegal1));

  imm_gen_pipe #(.XLEN(32), .DEPTH(2)) u_d2 (
    .clk(clk), .reset(rst2), .flush(flush2), .in_valid(in_valid2), .in_ready(in_ready2),
    .inst(inst2), .out_valid(out_valid2), .out_ready(out_ready2), .imm_out(imm2),
    .fmt(fmt2), .illegal(illegal2));

  imm_gen_pipe #(.XLEN(32), .DEPTH(3)) u_d3 (
    .clk(clk), .reset(rst3), .flush(flush3), .in_valid(in_valid3), .in_ready(in_ready3),
    .inst(inst3), .out_valid(out_valid3), .out_ready(out_ready3), .imm_out(imm3),
    .fmt(fmt3), .illegal(illegal3));

  imm_gen_pipe #(.XLEN(64), .DEPTH(1)) u_d64 (
    .clk(clk), .reset(rst64), .flush(flush64), .in_valid(in_valid64), .in_ready(in_ready64),
    .inst(inst64), .out_valid(out_valid64), .out_ready(out_ready64), .imm_out(imm64),
    .fmt(fmt64), .illegal(illegal64));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] word);
    in_valid1 = 1'b1;
    inst1     = word;
  endtask

  logic [31:0] v_inst [10];
  logic [63:0] v_imm  [10];
  logic [2:0]  v_fmt  [10];
  logic        v_ill  [10];
  logic [31:0] w_inst [5];
  logic [63:0] w_imm  [5];
  logic [2:0]  w_fmt  [5];
  logic        w_ill  [5];
  logic [31:0] bp_vec [4];
  int          acc, got;
  logic        fire, ofire;

  initial begin
    tests_run = 0;
    tests_failed = 0;

    v_inst[0] = 32'hFFF00093; v_imm[0] = 64'hFFFFFFFF; v_fmt[0] = 3'd1; v_ill[0] = 1'b0;
    v_inst[1] = 32'hFE20AE23; v_imm[1] = 64'hFFFFFFFC; v_fmt[1] = 3'd2; v_ill[1] = 1'b0;
    v_inst[2] = 32'hFE000CE3; v_imm[2] = 64'hFFFFFFF8; v_fmt[2] = 3'd3; v_ill[2] = 1'b0;
    v_inst[3] = 32'h123452B7; v_imm[3] = 64'h12345000; v_fmt[3] = 3'd4; v_ill[3] = 1'b0;
    v_inst[4] = 32'h001000EF; v_imm[4] = 64'h00000800; v_fmt[4] = 3'd5; v_ill[4] = 1'b0;
    v_inst[5] = 32'h0000007F; v_imm[5] = 64'h0;        v_fmt[5] = 3'd0; v_ill[5] = 1'b1;
    v_inst[6] = 32'h002081B3; v_imm[6] = 64'h0;        v_fmt[6] = 3'd0; v_ill[6] = 1'b0;
    v_inst[7] = 32'h00812083; v_imm[7] = 64'h8;        v_fmt[7] = 3'd1; v_ill[7] = 1'b0;
    v_inst[8] = 32'h4030D093; v_fmt[8] = 3'd1; v_ill[8] = 1'b0;
    v_inst[9] = 32'h02109093; v_fmt[9] = 3'd1;
    w_inst[0] = 32'hFFF00093; w_imm[0] = 64'hFFFFFFFFFFFFFFFF; w_fmt[0] = 3'd1; w_ill[0] = 1'b0;
    w_inst[1] = 32'h02109093; w_imm[1] = 64'd33;               w_fmt[1] = 3'd1; w_ill[1] = 1'b0;
    w_inst[2] = 32'h4030D093; w_fmt[2] = 3'd1;                 w_ill[2] = 1'b0;
    w_inst[3] = 32'h823452B7; w_imm[3] = 64'hFFFFFFFF82345000; w_fmt[3] = 3'd4; w_ill[3] = 1'b0;
    w_inst[4] = 32'hFE000CE3; w_imm[4] = 64'hFFFFFFFFFFFFFFF8; w_fmt[4] = 3'd3; w_ill[4] = 1'b0;
`ifdef IMM_GEN_SHAMT_EN
    v_imm[8] = 64'h3;   v_imm[9] = 64'h1;  v_ill[9] = 1'b1;
    w_imm[2] = 64'h3;
`else
    v_imm[8] = 64'h403; v_imm[9] = 64'h21; v_ill[9] = 1'b0;
    w_imm[2] = 64'h403;
`endif
    bp_vec[0] = 32'h00100093; bp_vec[1] = 32'h00200093;
    bp_vec[2] = 32'h00300093; bp_vec[3] = 32'h00400093;

    {rst1, rst2, rst3, rst64} = 4'hF;
    {flush1, flush2, flush3, flush64} = 4'h0;
    {in_valid1, in_valid2, in_valid3, in_valid64} = 4'h0;
    {out_ready1, out_ready2, out_ready3, out_ready64} = 4'hF;
    inst1 = '0; inst2 = '0; inst3 = '0; inst64 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    {rst1, rst2, rst3, rst64} = 4'h0;
    #1;
    checkOutput("rst_out_valid", 64'(out_valid1), 64'd0);
    checkOutput("rst_imm", 64'(imm1), 64'd0);
    checkOutput("rst_fmt", 64'(fmt1), 64'd0);
    checkOutput("rst_illegal", 64'(illegal1), 64'd0);
    checkOutput("rst_in_ready", 64'(in_ready1), 64'd1);
    checkOutput("rst_imm64", imm64, 64'd0);

    // Decode stream, XLEN=32 DEPTH=1: each result appears one cycle after its input.
    applyStimulus(v_inst[0]);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      checkOutput($sformatf("d1_valid[%0d]", i), 64'(out_valid1), 64'd1);
      checkOutput($sformatf("d1_imm[%0d]", i), 64'(imm1), v_imm[i]);
      checkOutput($sformatf("d1_fmt[%0d]", i), 64'(fmt1), 64'(v_fmt[i]));
      checkOutput($sformatf("d1_illegal[%0d]", i), 64'(illegal1), 64'(v_ill[i]));
      if (i < 9) applyStimulus(v_inst[i+1]);
      else in_valid1 = 1'b0;
    end
    @(negedge clk); #1;
    checkOutput("d1_drain_valid", 64'(out_valid1), 64'd0);

    // XLEN=64 decode.
    in_valid64 = 1'b1; inst64 = w_inst[0];
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      checkOutput($sformatf("d64_valid[%0d]", i), 64'(out_valid64), 64'd1);
      checkOutput($sformatf("d64_imm[%0d]", i), imm64, w_imm[i]);
      checkOutput($sformatf("d64_fmt[%0d]", i), 64'(fmt64), 64'(w_fmt[i]));
      checkOutput($sformatf("d64_illegal[%0d]", i), 64'(illegal64), 64'(w_ill[i]));
      if (i < 4) inst64 = w_inst[i+1];
      else in_valid64 = 1'b0;
    end

    // Backpressure, DEPTH=2: stall output for three cycles, then drain in order.
    @(negedge clk);
    out_ready2 = 1'b0; in_valid2 = 1'b1; inst2 = bp_vec[0];
    acc = 0; got = 0;
    for (int c = 0; c < 40 && got < 4; c++) begin
      if (c == 5) out_ready2 = 1'b1;
      #1;
      if (c == 2) begin
        checkOutput("bp_in_ready_low", 64'(in_ready2), 64'd0);
        checkOutput("bp_accepted", 64'(acc), 64'd2);
      end
      if (c >= 2 && c <= 4) begin
        checkOutput($sformatf("bp_hold_valid[%0d]", c), 64'(out_valid2), 64'd1);
        checkOutput($sformatf("bp_hold_imm[%0d]", c), 64'(imm2), 64'd1);
      end
      fire  = in_valid2 && in_ready2;
      ofire = out_valid2 && out_ready2;
      if (ofire) begin
        checkOutput($sformatf("bp_order[%0d]", got), 64'(imm2), 64'(got + 1));
        got++;
      end
      @(negedge clk);
      if (fire) begin
        acc++;
        if (acc < 4) inst2 = bp_vec[acc];
        else in_valid2 = 1'b0;
      end
    end
    checkOutput("bp_all_drained", 64'(got), 64'd4);
    #1;
    checkOutput("bp_no_duplicate", 64'(out_valid2), 64'd0);

    // Flush, DEPTH=3: fill, flush with a competing input, then time a fresh entry.
    @(negedge clk);
    in_valid3 = 1'b1; inst3 = bp_vec[0];
    @(negedge clk); inst3 = bp_vec[1];
    @(negedge clk); inst3 = bp_vec[2];
    @(negedge clk); #1;
    checkOutput("fl_first_latency_valid", 64'(out_valid3), 64'd1);
    checkOutput("fl_first_latency_imm", 64'(imm3), 64'd1);
    flush3 = 1'b1; inst3 = bp_vec[3];
    @(negedge clk);
    flush3 = 1'b0; inst3 = 32'h00500093;
    #1;
    checkOutput("fl_valid_cleared", 64'(out_valid3), 64'd0);
    checkOutput("fl_data_kept", 64'(imm3), 64'd1);
    checkOutput("fl_in_ready", 64'(in_ready3), 64'd1);
    @(negedge clk); in_valid3 = 1'b0; #1;
    checkOutput("fl_lat1", 64'(out_valid3), 64'd0);
    @(negedge clk); #1;
    checkOutput("fl_lat2", 64'(out_valid3), 64'd0);
    @(negedge clk); #1;
    checkOutput("fl_lat3_valid", 64'(out_valid3), 64'd1);
    checkOutput("fl_lat3_imm", 64'(imm3), 64'd5);
    @(negedge clk); #1;
    checkOutput("fl_after", 64'(out_valid3), 64'd0);

    // Mid-stream reset, DEPTH=2: two entries in flight, output stalled.
    out_ready2 = 1'b0; in_valid2 = 1'b1; inst2 = 32'h00700093;
    @(negedge clk); inst2 = 32'h00900093;
    @(negedge clk); #1;
    checkOutput("mr_before_valid", 64'(out_valid2), 64'd1);
    checkOutput("mr_before_imm", 64'(imm2), 64'd7);
    checkOutput("mr_before_ready", 64'(in_ready2), 64'd0);
    rst2 = 1'b1;
    @(negedge clk);
    rst2 = 1'b0; in_valid2 = 1'b0;
    #1;
    checkOutput("mr_valid", 64'(out_valid2), 64'd0);
    checkOutput("mr_imm", 64'(imm2), 64'd0);
    checkOutput("mr_fmt", 64'(fmt2), 64'd0);
    checkOutput("mr_in_ready", 64'(in_ready2), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
